fn_sw_arb: RTL

Round-robin scheduler that shares one W-bit AND/XOR function unit among N requesters. The unit computes sel ? a&b : a^b. The block arbitrates between requests, latches the winner's operands and sel, and sequences one operation at a time. It returns a registered result, tagged with the requester id, over a valid/ready output handshake. It sits between multiple client blocks and the shared logic-op datapath.

---
 rtl/fn_sw_arb.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fn_sw_arb.sv
// -----------------------------------------------------------------------------
// fn_sw_arb
//
// Round-robin scheduler sharing one W-bit logic-op unit (sel ? a&b : a^b)
// among N requesters. One operation is in flight at a time:
//   IDLE -> (grant, latch operands) -> EXEC -> (compute) -> HOLD -> handshake
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req        per-requester request, bit i = requester i
//   a_flat     operand a, requester i uses [i*W +: W]
//   b_flat     operand b, same slicing
//   sel        per-requester op select (1 = AND, 0 = XOR)
//   gnt        one-hot grant, one-cycle pulse when operands are latched
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_data   result
//   out_id     requester that owns out_data
//   busy       high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module fn_sw_arb #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IDW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   a_flat,
  input  logic [N*W-1:0]   b_flat,
  input  logic [N-1:0]     sel,
  output logic [N-1:0]     gnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [IDW-1:0]   out_id,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [W-1:0]     a_l_q, a_l_d;
  logic [W-1:0]     b_l_q, b_l_d;
  logic             sel_l_q, sel_l_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [IDW-1:0]   out_id_q, out_id_d;

  // Winner search: first set req bit scanning ptr, ptr+1, ..., wrapping.
  logic           win_found;
  logic [IDW-1:0] win_idx;
  int             win_int;

  always_comb begin
    int idx;
    win_found = 1'b0;
    win_int   = 0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_int   = idx;
      end
    end
    win_idx = IDW'(win_int);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = '0;
    a_l_d       = a_l_q;
    b_l_d       = b_l_q;
    sel_l_d     = sel_l_q;
    id_d        = id_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d          = '0;
          gnt_d[win_int] = 1'b1;
          a_l_d          = a_flat[win_int*W +: W];
          b_l_d          = b_flat[win_int*W +: W];
          sel_l_d        = sel[win_int];
          id_d           = win_idx;
          // Pointer moves just past the winner so it has lowest priority next.
          ptr_d          = (win_int == N-1) ? '0 : win_idx + IDW'(1);
          state_d        = EXEC;
        end
      end
      EXEC: begin
        out_data_d  = sel_l_q ? (a_l_q & b_l_q) : (a_l_q ^ b_l_q);
        out_id_d    = id_q;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      a_l_q       <= '0;
      b_l_q       <= '0;
      sel_l_q     <= 1'b0;
      id_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      a_l_q       <= a_l_d;
      b_l_q       <= b_l_d;
      sel_l_q     <= sel_l_d;
      id_q        <= id_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign gnt       = gnt_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign busy      = (state_q != IDLE);

endmodule
